// File: rtl/bch_correct_buffer.sv
// Holds the received data word through BCH decode, XORs in the Chien error stream
// beat by beat, and presents the corrected word with a decode-failure flag.
module bch_correct_buffer #(
   parameter  int DATA_BITS = 5,
   parameter  int BITS      = 1,
   parameter  int ERR_W     = 2,
   localparam int NBEATS    = DATA_BITS / BITS,
   localparam int CNT_W     = $clog2(NBEATS + 1),
   localparam int CC_W      = $clog2(DATA_BITS + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [DATA_BITS-1:0] code_data_in,
   output logic                 load_ready,
   input  logic                 err_count_valid,
   input  logic [ERR_W-1:0]     err_count,
   input  logic                 err_first,
   input  logic                 err_valid,
   input  logic                 err_last,
   input  logic [BITS-1:0]      err,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 out_valid,
   input  logic                 out_ack,
   output logic [CC_W-1:0]      corr_count,
   output logic                 fail
);

   localparam logic [CNT_W-1:0] NB = CNT_W'(NBEATS);

   typedef enum logic [1:0] {IDLE, WAIT, CORR, DONE} state_t;

   state_t               state, state_nx;
   logic [DATA_BITS-1:0] word, word_nx, raw, raw_nx;
   logic [CC_W-1:0]      cc_nx, pop;
   logic [CNT_W-1:0]     beat_cnt, bc_nx;
   logic [ERR_W-1:0]     ec, ec_nx;
   logic                 fail_nx, beat, restart;

   always_comb begin
      pop = '0;
      for (int i = 0; i < BITS; i++) pop = pop + CC_W'(err[i]);
   end

   always_comb begin
      state_nx = state;
      word_nx  = word;
      raw_nx   = raw;
      cc_nx    = corr_count;
      bc_nx    = beat_cnt;
      ec_nx    = ec;
      fail_nx  = fail;
      beat     = 1'b0;
      restart  = 1'b0;
      case (state)
         IDLE: if (load) begin
            raw_nx   = code_data_in;
            word_nx  = code_data_in;
            cc_nx    = '0;
            bc_nx    = '0;
            fail_nx  = 1'b0;
            state_nx = WAIT;
         end
         WAIT: begin
            if (err_count_valid) ec_nx = err_count;
            if (err_first) begin
               beat     = 1'b1;
               restart  = 1'b1;
               state_nx = err_last ? DONE : CORR;
            end
         end
         CORR: begin
            if (err_count_valid) ec_nx = err_count;
            beat    = err_first | err_valid;
            restart = err_first;
            if (err_last) state_nx = DONE;
         end
         DONE: if (out_ack) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase

      // A restart rebuilds from the uncorrected copy so repeated passes are exact
      if (beat) begin
         if (restart) begin
            word_nx = raw;
            cc_nx   = '0;
            bc_nx   = '0;
         end
         if (bc_nx < NB) begin
            for (int b = 0; b < NBEATS; b++)
               if (bc_nx == CNT_W'(b)) word_nx[b*BITS +: BITS] = word_nx[b*BITS +: BITS] ^ err;
            cc_nx = cc_nx + pop;
            bc_nx = bc_nx + CNT_W'(1);
         end
      end

      if (state != DONE && state_nx == DONE)
         fail_nx = (32'(cc_nx) != 32'(ec_nx)) || (bc_nx < NB);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         word       <= '0;
         raw        <= '0;
         corr_count <= '0;
         beat_cnt   <= '0;
         ec         <= '0;
         fail       <= 1'b0;
      end else begin
         state      <= state_nx;
         word       <= word_nx;
         raw        <= raw_nx;
         corr_count <= cc_nx;
         beat_cnt   <= bc_nx;
         ec         <= ec_nx;
         fail       <= fail_nx;
      end
   end

   assign load_ready = (state == IDLE);
   assign out_valid  = (state == DONE);
   assign data_out   = word;

endmodule

// File: tb/tb_bch_correct_buffer.sv
// Directed bench for bch_correct_buffer at DATA_BITS=5, BITS=1, ERR_W=2.
module tb_bch_correct_buffer;

   logic       clk = 1'b0;
   logic       rst;
   logic       load;
   logic [4:0] code_data_in;
   logic       load_ready;
   logic       err_count_valid;
   logic [1:0] err_count;
   logic       err_first, err_valid, err_last;
   logic [0:0] err;
   logic [4:0] data_out;
   logic       out_valid;
   logic       out_ack;
   logic [2:0] corr_count;
   logic       fail;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   bch_correct_buffer #(.DATA_BITS(5), .BITS(1), .ERR_W(2)) dut (
      .clk(clk), .rst(rst), .load(load), .code_data_in(code_data_in),
      .load_ready(load_ready), .err_count_valid(err_count_valid), .err_count(err_count),
      .err_first(err_first), .err_valid(err_valid), .err_last(err_last), .err(err),
      .data_out(data_out), .out_valid(out_valid), .out_ack(out_ack),
      .corr_count(corr_count), .fail(fail)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      load = 0; err_count_valid = 0; err_first = 0; err_valid = 0;
      err_last = 0; err = 0; out_ack = 0;
   endtask

   // load a word, latch err_count, leave the buffer in WAIT
   task automatic load_word(input logic [4:0] d, input logic [1:0] ec);
      idle_in();
      load = 1; code_data_in = d;
      step();
      load = 0;
      err_count_valid = 1; err_count = ec;
      step();
      err_count_valid = 0;
   endtask

   task automatic beat(input logic f, input logic v, input logic l, input logic e);
      err_first = f; err_valid = v; err_last = l; err = e;
      step();
      idle_in();
   endtask

   // full pass over n beats; checks the 1-cycle latency of out_valid
   task automatic pass(input string tag, input logic [4:0] errs, input int n);
      for (int k = 0; k < n; k++) begin
         if (k == n - 1) chk({tag, "_ov_before"}, out_valid, 0);
         beat(k == 0, k != 0, k == n - 1, errs[k]);
      end
      chk({tag, "_ov_after"}, out_valid, 1);
   endtask

   task automatic ack();
      out_ack = 1;
      step();
      out_ack = 0;
   endtask

   initial begin
      idle_in();
      code_data_in = 0; err_count = 0;
      rst = 0;
      step(); step();
      chk("rst_load_ready", load_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_data_out", data_out, 0);
      chk("rst_corr_count", corr_count, 0);
      chk("rst_fail", fail, 0);
      rst = 1;
      step();

      // two errors corrected, count agrees
      load_word(5'b00011, 2'd2);
      chk("t1_load_ready", load_ready, 0);
      pass("t1", 5'b01001, 5);
      chk("t1_data", data_out, 5'b01010);
      chk("t1_cc", corr_count, 2);
      chk("t1_fail", fail, 0);
      ack();

      // no errors flipped but sigma claims one
      load_word(5'b00011, 2'd1);
      pass("t2", 5'b00000, 5);
      chk("t2_data", data_out, 5'b00011);
      chk("t2_cc", corr_count, 0);
      chk("t2_fail", fail, 1);
      ack();

      // short pass of 3 beats
      load_word(5'b00011, 2'd0);
      pass("t3", 5'b00000, 3);
      chk("t3_data", data_out, 5'b00011);
      chk("t3_fail", fail, 1);
      ack();

      // restart mid-pass
      load_word(5'b00011, 2'd1);
      beat(1, 0, 0, 1);
      chk("t4_beat0", data_out, 5'b00010);
      beat(0, 1, 0, 1);
      chk("t4_beat1", data_out, 5'b00000);
      pass("t4", 5'b00100, 5);
      chk("t4_data", data_out, 5'b00111);
      chk("t4_cc", corr_count, 1);
      chk("t4_fail", fail, 0);

      // output held through a 3-cycle ack stall; load in DONE ignored
      load = 1; code_data_in = 5'b11111;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t5_ov_hold", out_valid, 1);
         chk("t5_data_hold", data_out, 5'b00111);
         chk("t5_lr_hold", load_ready, 0);
      end
      load = 0; out_ack = 1;
      step();
      out_ack = 0;
      chk("t5_ov_after_ack", out_valid, 0);
      chk("t5_lr_after_ack", load_ready, 1);
      load = 1; code_data_in = 5'b11100;
      step();
      load = 0;
      chk("t5_new_load", load_ready, 0);
      chk("t5_new_data", data_out, 5'b11100);

      // async reset during CORR
      beat(1, 0, 0, 1);
      chk("t6_corr_data", data_out, 5'b11101);
      rst = 0;
      #1;
      chk("t6_rst_data", data_out, 0);
      chk("t6_rst_lr", load_ready, 1);
      chk("t6_rst_ov", out_valid, 0);
      chk("t6_rst_cc", corr_count, 0);
      chk("t6_rst_fail", fail, 0);
      rst = 1;
      beat(0, 1, 0, 1);
      chk("t6_post_lr", load_ready, 1);
      chk("t6_post_data", data_out, 0);
      chk("t6_post_ov", out_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/bch_correct_buffer.md
# bch_correct_buffer

Holds the received data portion of a BCH codeword while the syndrome, sigma (BMA) and Chien-search stages run. It applies the Chien error stream (`err`, framed by `err_first`/`err_valid`/`err_last`) to the held word by XOR. It then presents the corrected word with a valid/ack handshake. It sits directly downstream of the Chien error locator and chien counter, and is the final stage of the PUF key-reconstruction decode path. It also flags decode failure when the number of corrected bits disagrees with the error count reported by the sigma stage.

## Interface
- `DATA_BITS`, default 5: data bits per codeword. Must be a multiple of `BITS`.
- `BITS`, default 1: error-stream bits per beat.
- `ERR_W`, default 2: width of the `err_count` input.
- `clk`  in  1  rising-edge clock, single clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `load`  in  1  request to capture `code_data_in`.
- `code_data_in`  in  DATA_BITS  received (uncorrected) data bits.
- `load_ready`  out  1  buffer idle; `load` is accepted.
- `err_count_valid`  in  1  strobe that qualifies `err_count`.
- `err_count`  in  ERR_W  number of errors located by the sigma stage.
- `err_first`  in  1  first Chien beat (beat 0).
- `err_valid`  in  1  subsequent Chien beat.
- `err_last`  in  1  final data beat; coincides with the beat it marks.
- `err`  in  BITS  error mask for the current beat.
- `data_out`  out  DATA_BITS  corrected word.
- `out_valid`  out  1  `data_out`, `corr_count` and `fail` are valid.
- `out_ack`  in  1  consumer accepts the output.
- `corr_count`  out  clog2(DATA_BITS+1)  number of bits flipped.
- `fail`  out  1  `corr_count` is not equal to the latched `err_count`, or the beat count is short.

## Operation
- State machine states: IDLE, WAIT, CORR, DONE. Reset enters IDLE. Reset values: `load_ready`=1, `out_valid`=0, `data_out`=0, `corr_count`=0, `fail`=0; the beat counter and latched `err_count` clear to 0.
- IDLE: when `load` is high, latch `code_data_in` into the word register, clear `corr_count`, the beat counter and `fail`, then go to WAIT. `load_ready` is 1 only in IDLE; `load` in any other state is ignored.
- `err_count_valid` in WAIT or CORR latches `err_count`. The last strobe wins. The strobe is ignored in IDLE and DONE.
- WAIT: on `err_first`, process beat 0 and go to CORR. `err_valid`/`err_last` without `err_first` are ignored.
- Processing beat k: word bits [k*BITS +: BITS] ^= `err`. `corr_count` += popcount(`err`). The beat counter increments. Beat 0 maps to the LSBs.
- CORR: each `err_valid` cycle processes the next beat.
  - Beats with k >= DATA_BITS/BITS are dropped.
  - `err_first` in CORR restarts the pass: reload the word from its uncorrected copy, clear the count, then process that beat as beat 0.
  - `err_last` goes to DONE.
  - `err_first` with `err_last` in the same cycle (DATA_BITS==BITS) processes beat 0 and goes directly to DONE.
- DONE: `out_valid`=1, and the outputs are held stable.
  - `fail` = (`corr_count` != zero-extended latched `err_count`) OR (beats processed < DATA_BITS/BITS).
  - `out_ack` with `out_valid` returns to IDLE. `out_ack` at any other time is ignored.
- The uncorrected copy of the word is kept so that a restart is exact. `data_out` is the working word register.
- `rst` asserted in any state aborts immediately to the reset values. A partially loaded word is discarded.

## Timing
- `load` sampled at edge N: `load_ready`=0 from N+1.
- `err_first` at edge M: the beat 0 XOR is visible in `data_out` from M+1.
- The `err_last` beat at edge L: `out_valid`=1 from L+1, with the final `data_out`/`corr_count`/`fail`. Latency is 1 cycle.
- `out_ack` at edge A (with `out_valid` high): `out_valid`=0 and `load_ready`=1 from A+1. The earliest next `load` is accepted at A+1.
- The beat rate is up to one beat per cycle. Gaps are allowed: a cycle with `err_valid`=0 does not advance.
- Counter widths: the beat counter is clog2(DATA_BITS/BITS+1) and saturates at DATA_BITS/BITS. `corr_count` cannot overflow, because at most DATA_BITS bits can flip.

## Test plan
- DATA_BITS=5, BITS=1: load 5'b00011. err_count=2. Beats `err`=1,0,0,1,0 with `err_last` on beat 4 → `data_out`=5'b01010, `corr_count`=2, `fail`=0, `out_valid` exactly 1 cycle after `err_last`.
- Same load with all-zero beats and err_count=1 → `data_out`=5'b00011, `corr_count`=0, `fail`=1.
- `err_last` on beat 2 (short pass), err_count=0, all errors zero → `fail`=1, `data_out` unchanged.
- Mid-pass `err_first` after 2 beats with `err`=1,1, then a full pass with `err`=0,0,1,0,0 → `data_out`=5'b00111, `corr_count`=1.
- `load` while in DONE is ignored. `out_valid` is held for 3 cycles until `out_ack`; `load_ready`=1 on the next cycle, and a new load is accepted.
- Assert `rst` during CORR → all outputs at reset values on the next sample. A following `err_valid` is ignored, and `load_ready`=1.
